overture_bus_sequencer: RTL
===========================

Name: overture_bus_sequencer

Overview:
- Multi-cycle control sequencer for the OVERTURE 8-bit shared-bus datapath: six general registers (reg0..reg5), an input port and an output port.
- Accepts one instruction byte per valid/ready handshake and decodes it.
- Drives the register load (bus-drive) and save (capture) strobes, the immediate driver, and the ALU/condition enables, with a programmable bus-settle window before the commit cycle.
- Sits between instruction fetch and the register/ALU datapath.

Parameters:
- SETTLE_CYCLES, 1, number of cycles the bus is driven before the commit cycle (0..15; 0 skips SETTLE).
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction byte offered.
- instr  input  8  instruction byte: [7:6] opcode, [5:0] operand.
- instr_ready  output  1  sequencer can accept an instruction.
- reg_load  output  6  one-hot: reg_n drives the bus.
- reg_save  output  6  one-hot: reg_n captures the bus.
- in_load  output  1  input port drives the bus.
- out_save  output  1  output port captures the bus.
- imm_en  output  1  immediate driver drives the bus.
- imm_value  output  8  {2'b00, operand[5:0]}.
- alu_en  output  1  ALU drives the bus from reg1/reg2.
- alu_op  output  3  ALU function code.
- cond_en  output  1  condition unit evaluates reg3.
- cond_code  output  3  condition code.
- done  output  1  one-cycle pulse: instruction committed.
- fault  output  1  one-cycle pulse: illegal instruction dropped.
- busy  output  1  state is not IDLE.
- instr_count  output  COUNT_WIDTH  retired instructions; wraps.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All strobes, enables, done, fault, busy, instr_count, imm_value, alu_op and cond_code go to 0. instr_ready=1 once rst=1. A reset mid-instruction drops the instruction with no commit.
- States: IDLE, SETTLE, COMMIT, FAULT. instr_ready=1 only in IDLE.
- IDLE: on instr_valid&&instr_ready, latch instr and decode.
  - Legal instruction: go to SETTLE (SETTLE_CYCLES>0) or directly to COMMIT (SETTLE_CYCLES=0).
  - Illegal instruction: go to FAULT.
- Decode:
  - 00 IMMEDIATE: imm_en=1, imm_value=operand; save target reg0.
  - 01 CALCULATE: reg_load[1] and reg_load[2], alu_en=1, alu_op=instr[2:0]; save target reg3. instr[5:3] ignored.
  - 10 COPY: src=instr[5:3], dst=instr[2:0]. src 0..5 -> reg_load[src]; src 6 -> in_load. dst 0..5 -> reg_save[dst]; dst 6 -> out_save. src=7 or dst=7 is illegal.
  - 11 CONDITION: reg_load[3], cond_en=1, cond_code=instr[2:0]; no save target.
- SETTLE: drive-side outputs (reg_load, in_load, imm_en, alu_en, cond_en, with codes) asserted. All save-side outputs are 0. A counter runs SETTLE_CYCLES cycles, then the state goes to COMMIT.
- COMMIT: exactly 1 cycle. Drive-side outputs stay asserted; the save target is asserted; done=1; instr_count+=1 (modulo 2^COUNT_WIDTH). Next state IDLE.
- FAULT: exactly 1 cycle. fault=1; all strobes 0; instr_count unchanged. Next state IDLE.
- Outputs are registered from state and the latched instruction; no combinational path from instr to strobes.
- Latency: accept at edge k; drive from cycle k+1; commit at cycle k+1+SETTLE_CYCLES; instr_ready=1 again at cycle k+2+SETTLE_CYCLES. Throughput is one instruction per SETTLE_CYCLES+2 cycles.
- COPY with src==dst (0..5): load and save of the same register are asserted together in COMMIT. This is legal.
- COPY 6->6: in_load and out_save, legal.
- instr_valid while busy is ignored. The held instr is not consumed until IDLE.
- Strobes are zero in IDLE; at most one save-side bit is set in any cycle.

Test Plan:
- Reset, SETTLE_CYCLES=1, instr=0x2A (IMM 42) -> cycle k+1: imm_en=1, imm_value=0x2A, reg_save=0. Cycle k+2: reg_save=000001, done=1, instr_count=1. Cycle k+3: instr_ready=1.
- instr=0x9D (COPY 3->5) -> reg_load=001000 for 2 cycles; reg_save=100000 only in the 2nd cycle.
- instr=0xB6 (COPY 6->6) -> in_load=1, out_save=1 in COMMIT; instr=0xBF (dst 7) -> fault pulse, no strobes, instr_count unchanged, ready after 1 cycle.
- instr=0x44 (CALC op 4) -> reg_load=000110, alu_en=1, alu_op=4, reg_save=001000 at commit. Then instr=0xC3 (COND 3) -> reg_load=001000, cond_en=1, done=1, reg_save=0.
- SETTLE_CYCLES=0, back-to-back valid -> accepts every 2nd cycle. With COUNT_WIDTH=4, 17 commits -> instr_count=1.
- Assert rst=0 during SETTLE of a COPY -> all strobes 0 immediately, no done, instr_count=0. After release, IDLE with ready=1.

Source files
------------

// File: rtl/overture_bus_sequencer.sv
// ---------------------------------------------------------------------------
// overture_bus_sequencer
//
// Purpose:
//   Multi-cycle control sequencer for the OVERTURE 8-bit shared-bus datapath
//   (reg0..reg5, an input port and an output port). It takes one instruction
//   byte per valid/ready handshake, decodes it, and drives the bus-drive and
//   bus-capture strobes. After an optional bus-settle window, one commit
//   cycle follows.
//
// Parameters:
//   SETTLE_CYCLES  cycles the bus is driven before the commit cycle (0..15)
//   COUNT_WIDTH    width of the retired-instruction counter
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   instr_valid  instruction byte offered
//   instr        [7:6] opcode, [5:0] operand
//   instr_ready  sequencer idle and able to accept
//   reg_load     one-hot, register n drives the bus
//   reg_save     one-hot, register n captures the bus
//   in_load      input port drives the bus
//   out_save     output port captures the bus
//   imm_en       immediate driver drives the bus
//   imm_value    zero-extended 6-bit operand
//   alu_en       ALU drives the bus from reg1/reg2
//   alu_op       ALU function code
//   cond_en      condition unit evaluates reg3
//   cond_code    condition code
//   done         one-cycle pulse, instruction committed
//   fault        one-cycle pulse, illegal instruction dropped
//   busy         sequencer not idle
//   instr_count  retired instruction count, wraps
// ---------------------------------------------------------------------------
module overture_bus_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [7:0]             instr,
  output logic                   instr_ready,
  output logic [5:0]             reg_load,
  output logic [5:0]             reg_save,
  output logic                   in_load,
  output logic                   out_save,
  output logic                   imm_en,
  output logic [7:0]             imm_value,
  output logic                   alu_en,
  output logic [2:0]             alu_op,
  output logic                   cond_en,
  output logic [2:0]             cond_code,
  output logic                   done,
  output logic                   fault,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT,
    ST_FAULT
  } state_t;

  // Everything the datapath needs from one instruction, split into the
  // drive side (loads, immediate, ALU, condition) and the save side.
  typedef struct packed {
    logic       legal;
    logic [5:0] loadMask;
    logic       inLoad;
    logic       immEn;
    logic [7:0] immValue;
    logic       aluEn;
    logic [2:0] aluOp;
    logic       condEn;
    logic [2:0] condCode;
    logic [5:0] saveMask;
    logic       outSave;
  } decode_t;

  // The settle counter is loaded with SETTLE_CYCLES-1 at accept and reaching
  // zero in SETTLE means the last settle cycle is in progress.
  localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);
  localparam logic [3:0] SETTLE_LOAD = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  // Opcode map: 00 immediate into reg0, 01 ALU reg1/reg2 into reg3,
  // 10 copy src->dst (index 6 is the I/O port, 7 is illegal), 11 condition
  // on reg3 with no save target.
  function automatic decode_t decodeInstr(input logic [7:0] b);
    decode_t    d;
    logic [2:0] src;
    logic [2:0] dst;
    d       = '0;
    d.legal = 1'b1;
    src     = b[5:3];
    dst     = b[2:0];
    case (b[7:6])
      2'b00: begin
        d.immEn    = 1'b1;
        d.immValue = {2'b00, b[5:0]};
        d.saveMask = 6'b000001;
      end
      2'b01: begin
        d.loadMask = 6'b000110;
        d.aluEn    = 1'b1;
        d.aluOp    = b[2:0];
        d.saveMask = 6'b001000;
      end
      2'b10: begin
        if ((src == 3'd7) || (dst == 3'd7)) begin
          d.legal = 1'b0;
        end
        if (src < 3'd6) begin
          d.loadMask = 6'b000001 << src;
        end else begin
          d.inLoad = 1'b1;
        end
        if (dst < 3'd6) begin
          d.saveMask = 6'b000001 << dst;
        end else begin
          d.outSave = 1'b1;
        end
      end
      default: begin
        d.loadMask = 6'b001000;
        d.condEn   = 1'b1;
        d.condCode = b[2:0];
      end
    endcase
    return d;
  endfunction

  state_t           r_state;
  decode_t          r_dec;
  logic [3:0]       r_settleCnt;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [5:0] r_regLoad;
  logic [5:0] r_regSave;
  logic       r_inLoad;
  logic       r_outSave;
  logic       r_immEn;
  logic [7:0] r_immValue;
  logic       r_aluEn;
  logic [2:0] r_aluOp;
  logic       r_condEn;
  logic [2:0] r_condCode;
  logic       r_done;
  logic       r_fault;

  state_t     w_nextState;
  logic [3:0] w_nextCnt;
  logic       w_accept;
  decode_t    w_decNew;
  decode_t    w_dec;

  logic [5:0] w_regLoad;
  logic [5:0] w_regSave;
  logic       w_inLoad;
  logic       w_outSave;
  logic       w_immEn;
  logic [7:0] w_immValue;
  logic       w_aluEn;
  logic [2:0] w_aluOp;
  logic       w_condEn;
  logic [2:0] w_condCode;
  logic       w_done;
  logic       w_fault;

  // Only IDLE consumes instructions; a byte offered while busy stays on
  // the input until the sequencer returns to IDLE.
  assign w_accept = instr_valid && (r_state == ST_IDLE);
  assign w_decNew = decodeInstr(instr);
  assign w_dec    = w_accept ? w_decNew : r_dec;

  // Next-state and settle-counter logic. A legal instruction skips SETTLE
  // entirely when no settle window is configured.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_settleCnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextCnt = SETTLE_LOAD;
          if (!w_decNew.legal) begin
            w_nextState = ST_FAULT;
          end else if (HAS_SETTLE) begin
            w_nextState = ST_SETTLE;
          end else begin
            w_nextState = ST_COMMIT;
          end
        end
      end
      ST_SETTLE: begin
        if (r_settleCnt == 4'd0) begin
          w_nextState = ST_COMMIT;
        end else begin
          w_nextCnt = r_settleCnt - 4'd1;
        end
      end
      ST_COMMIT: w_nextState = ST_IDLE;
      ST_FAULT:  w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, computed from the state being
  // entered so that every strobe comes straight out of a flop. Drive-side
  // signals cover SETTLE and COMMIT; save-side signals and done only COMMIT.
  always_comb begin
    w_regLoad  = '0;
    w_regSave  = '0;
    w_inLoad   = 1'b0;
    w_outSave  = 1'b0;
    w_immEn    = 1'b0;
    w_immValue = '0;
    w_aluEn    = 1'b0;
    w_aluOp    = '0;
    w_condEn   = 1'b0;
    w_condCode = '0;
    w_done     = 1'b0;
    w_fault    = 1'b0;
    if ((w_nextState == ST_SETTLE) || (w_nextState == ST_COMMIT)) begin
      w_regLoad  = w_dec.loadMask;
      w_inLoad   = w_dec.inLoad;
      w_immEn    = w_dec.immEn;
      w_immValue = w_dec.immValue;
      w_aluEn    = w_dec.aluEn;
      w_aluOp    = w_dec.aluOp;
      w_condEn   = w_dec.condEn;
      w_condCode = w_dec.condCode;
    end
    if (w_nextState == ST_COMMIT) begin
      w_regSave = w_dec.saveMask;
      w_outSave = w_dec.outSave;
      w_done    = 1'b1;
    end
    if (w_nextState == ST_FAULT) begin
      w_fault = 1'b1;
    end
  end

  // State, latched instruction and counters. Reset drops any instruction
  // in flight without committing it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_dec       <= '0;
      r_settleCnt <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_nextState;
      r_settleCnt <= w_nextCnt;
      if (w_accept) begin
        r_dec <= w_decNew;
      end
      if (w_nextState == ST_COMMIT) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Registered strobes and codes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regLoad  <= '0;
      r_regSave  <= '0;
      r_inLoad   <= 1'b0;
      r_outSave  <= 1'b0;
      r_immEn    <= 1'b0;
      r_immValue <= '0;
      r_aluEn    <= 1'b0;
      r_aluOp    <= '0;
      r_condEn   <= 1'b0;
      r_condCode <= '0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_regLoad  <= w_regLoad;
      r_regSave  <= w_regSave;
      r_inLoad   <= w_inLoad;
      r_outSave  <= w_outSave;
      r_immEn    <= w_immEn;
      r_immValue <= w_immValue;
      r_aluEn    <= w_aluEn;
      r_aluOp    <= w_aluOp;
      r_condEn   <= w_condEn;
      r_condCode <= w_condCode;
      r_done     <= w_done;
      r_fault    <= w_fault;
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign reg_load    = r_regLoad;
  assign reg_save    = r_regSave;
  assign in_load     = r_inLoad;
  assign out_save    = r_outSave;
  assign imm_en      = r_immEn;
  assign imm_value   = r_immValue;
  assign alu_en      = r_aluEn;
  assign alu_op      = r_aluOp;
  assign cond_en     = r_condEn;
  assign cond_code   = r_condCode;
  assign done        = r_done;
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule
